dmem_responder: RTL and testbench

Memory-side responder for the pipeline's MEM-stage load/store port. It accepts one word-sized read or write request at a time over a valid/ready handshake, holds it for a programmable number of wait states, then returns read data or a write acknowledge with a one-cycle `resp_valid` pulse. While a request is outstanding it drives `mem_stall` so the pipeline can freeze PC, IF/ID, ID/EX and EX/MEM until the access completes.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, constants and address checks for the data-memory
//               responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Misaligned, or any address bit set above the word array.
    function automatic logic dmem_addr_err(input logic [31:0] addr, input int addr_w);
        logic [31:0] upper;
        upper = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : 2^ADDR_W x 32 storage, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage load/store responder with programmable wait states
//               and a pipeline stall output.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_stall
);

    localparam int         c_off_w    = $clog2(WORD_BYTES);
    localparam logic [3:0] c_cnt_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;

    logic                w_accept;
    logic                w_err_in;
    logic                w_commit;
    logic                w_acc_write;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [31:0]         w_acc_wdata;
    logic                w_acc_err;
    logic                w_mem_we;
    logic [31:0]         w_mem_rdata;
    logic [31:0]         w_resp_rdata;

    assign w_accept = req_valid & r_req_ready;
    assign w_err_in = dmem_addr_err(req_addr, ADDR_W);

    // With zero wait states the access happens on the accepting edge, so it
    // must use the live request rather than the latch.
    assign w_acc_write = (LATENCY == 0) ? req_write : r_write;
    assign w_acc_addr  = (LATENCY == 0) ? req_addr[ADDR_W+c_off_w-1:c_off_w] : r_addr;
    assign w_acc_wdata = (LATENCY == 0) ? req_wdata : r_wdata;
    assign w_acc_err   = (LATENCY == 0) ? w_err_in : r_err;

    assign w_commit = ((LATENCY == 0) && (r_state == IDLE) && w_accept) ||
                      ((r_state == WAIT) && (r_cnt == 4'd0));

    assign w_mem_we     = w_commit & w_acc_write & ~w_acc_err;
    assign w_resp_rdata = (w_acc_write | w_acc_err) ? 32'd0 : w_mem_rdata;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_acc_addr),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr[ADDR_W+c_off_w-1:c_off_w];
                        r_wdata     <= req_wdata;
                        r_err       <= w_err_in;
                        r_req_ready <= 1'b0;
                        if (LATENCY > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= c_cnt_init;
                        end else begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_resp_rdata;
                            r_resp_err   <= w_acc_err;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_resp_rdata;
                        r_resp_err   <= w_acc_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'd0;
                    r_resp_err   <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_stall  = req_valid & ~r_resp_valid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder at LATENCY 2 and 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        mem_stall  [2];

    int          lat_of [2] = '{2, 0};
    logic [31:0] model  [2][256];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            dmem_responder #(
                .ADDR_W  (AW),
                .LATENCY ((g == 0) ? 2 : 0)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .req_valid  (req_valid[g]),
                .req_ready  (req_ready[g]),
                .req_write  (req_write[g]),
                .req_addr   (req_addr[g]),
                .req_wdata  (req_wdata[g]),
                .resp_valid (resp_valid[g]),
                .resp_rdata (resp_rdata[g]),
                .resp_err   (resp_err[g]),
                .mem_stall  (mem_stall[g])
            );
        end
    endgenerate

    function automatic bit addr_bad(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= 4 * (1 << AW));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % 256);
    endfunction

    // One request from IDLE: returns response fields, cycles from presentation
    // to response, and number of stalled cycles before the response.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input bit churn, output logic [31:0] rd, output logic er,
                        output int lat, output int stalls);
        rd = 32'd0; er = 1'b0; lat = -1; stalls = 0;
        @(negedge clk);
        n_total++;
        if (req_ready[d] !== 1'b1) $display("FAIL ready_at_issue d%0d: got %b want 1", d, req_ready[d]);
        else n_pass++;
        req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
        #1;
        if (mem_stall[d] === 1'b1) stalls++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (resp_valid[d] === 1'b1) begin
                lat = c; rd = resp_rdata[d]; er = resp_err[d];
                n_total++;
                if (mem_stall[d] !== 1'b0) $display("FAIL stall_in_resp d%0d: got %b want 0", d, mem_stall[d]);
                else n_pass++;
                break;
            end
            if (mem_stall[d] === 1'b1) stalls++;
            if (churn) begin
                req_addr[d] = $urandom; req_wdata[d] = $urandom; req_write[d] = 1'($urandom);
            end
        end
        req_valid[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input bit churn, input string tag);
        logic [31:0] rd, exp_rd;
        logic        er;
        bit          exp_er;
        int          lat, st;
        exp_er = addr_bad(a);
        exp_rd = (wr || exp_er) ? 32'd0 : model[d][word_of(a)];
        xfer(d, wr, a, wd, churn, rd, er, lat, st);
        n_total++;
        if (lat !== lat_of[d] + 1) $display("FAIL %s latency d%0d: got %0d want %0d", tag, d, lat, lat_of[d] + 1);
        else n_pass++;
        n_total++;
        if (st !== lat_of[d] + 1) $display("FAIL %s stall_cycles d%0d: got %0d want %0d", tag, d, st, lat_of[d] + 1);
        else n_pass++;
        n_total++;
        if (er !== exp_er) $display("FAIL %s err d%0d addr %h: got %b want %b", tag, d, a, er, exp_er);
        else n_pass++;
        n_total++;
        if (rd !== exp_rd) $display("FAIL %s rdata d%0d addr %h: got %h want %h", tag, d, a, rd, exp_rd);
        else n_pass++;
        if (wr && !exp_er) model[d][word_of(a)] = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_write[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        req_valid[0] = 1'b1; req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (req_ready[d] !== 1'b1) $display("FAIL reset_ready d%0d: got %b want 1", d, req_ready[d]);
            else n_pass++;
            n_total++;
            if (resp_valid[d] !== 1'b0) $display("FAIL reset_valid d%0d: got %b want 0", d, resp_valid[d]);
            else n_pass++;
            n_total++;
            if (resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0)
                $display("FAIL reset_resp d%0d: got %h/%b want 0/0", d, resp_rdata[d], resp_err[d]);
            else n_pass++;
        end
        n_total++;
        if (mem_stall[0] !== 1'b1 || mem_stall[1] !== 1'b0)
            $display("FAIL reset_stall: got %b%b want 10", mem_stall[0], mem_stall[1]);
        else n_pass++;
        req_valid[0] = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                run_op(d, 1'b1, 32'(w * 4), $urandom, 1'b0, "fill");
    endtask

    task automatic test_store_load();
        run_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "st_10");
        run_op(0, 1'b0, 32'h10, 32'h0, 1'b0, "ld_10");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_write[1] = 1'b1; req_addr[1] = 32'h4; req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
        @(negedge clk);
        n_total++;
        if (resp_valid[1] !== 1'b1 || resp_err[1] !== 1'b0)
            $display("FAIL b2b_store_resp: got valid %b err %b want 1 0", resp_valid[1], resp_err[1]);
        else n_pass++;
        req_write[1] = 1'b0; req_wdata[1] = 32'hFFFFFFFF;
        @(negedge clk);
        n_total++;
        if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1)
            $display("FAIL b2b_gap: got valid %b ready %b want 0 1", resp_valid[1], req_ready[1]);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== 32'h12345678)
            $display("FAIL b2b_load_resp: got valid %b data %h want 1 12345678", resp_valid[1], resp_rdata[1]);
        else n_pass++;
        req_valid[1] = 1'b0;
        model[1][1] = 32'h12345678;
    endtask

    task automatic test_errors();
        for (int d = 0; d < 2; d++) begin
            run_op(d, 1'b0, 32'h2, 32'h0, 1'b0, "err_misalign");
            run_op(d, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, "err_range");
            run_op(d, 1'b0, 32'h0, 32'h0, 1'b0, "after_err");
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFEF00D; req_valid[0] = 1'b1;
        @(negedge clk);
        rst = 1'b1; req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid[0] === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL midwait_no_resp: got resp_valid 1 want 0");
        else n_pass++;
        run_op(0, 1'b0, 32'h20, 32'h0, 1'b0, "midwait_ld");
    endtask

    task automatic test_reset_in_resp();
        bit found;
        found = 1'b0;
        @(negedge clk);
        req_write[0] = 1'b0; req_addr[0] = 32'h30; req_valid[0] = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (resp_valid[0] === 1'b1) found = 1'b1;
        end
        req_valid[0] = 1'b0;
        n_total++;
        if (!found || resp_rdata[0] !== model[0][12])
            $display("FAIL inresp_pre: got found %b data %h want 1 %h", found, resp_rdata[0], model[0][12]);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0 || req_ready[0] !== 1'b1)
            $display("FAIL async_clear: got valid %b data %h ready %b want 0 0 1",
                     resp_valid[0], resp_rdata[0], req_ready[0]);
        else n_pass++;
        #1 rst = 1'b0;
        // A store that reached RESP before reset must stay written.
        run_op(0, 1'b1, 32'h34, 32'h0BADF00D, 1'b0, "inresp_st");
        @(negedge clk);
        req_write[0] = 1'b1; req_addr[0] = 32'h34; req_wdata[0] = 32'h11112222; req_valid[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (resp_valid[0] === 1'b1) found = 1'b1;
        end
        req_valid[0] = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model[0][13] = 32'h11112222;
        n_total++;
        if (!found) $display("FAIL inresp_st_resp: got no response want one");
        else n_pass++;
        run_op(0, 1'b0, 32'h34, 32'h0, 1'b0, "inresp_ld");
    endtask

    task automatic test_churn();
        for (int d = 0; d < 2; d++) begin
            run_op(d, 1'b1, 32'h18, 32'h600DCAFE + d, 1'b1, "churn_st");
            run_op(d, 1'b0, 32'h18, 32'h0, 1'b1, "churn_ld");
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                else if (r == 1) a = ($urandom & 32'hFFFFFFFC) | 32'h400;
                else             a = 32'($urandom_range(0, 15) * 4);
                run_op(d, 1'($urandom), a, $urandom, 1'($urandom), "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_reset_mid_wait();
        test_reset_in_resp();
        test_churn();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
